control_divisor: RTL and testbench
==================================

CONTROL_DIVISOR -- requirements
Module: control_divisor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  4  unsigned dividend; sampled on the accepting edge.
REQ-006 divisor  input  4  unsigned divisor; sampled on the accepting edge.
REQ-007 op_a  output  4  A operand to the external 4-bit adder/subtractor.
REQ-008 op_b  output  4  B operand to the external adder/subtractor.
REQ-009 op_cin  output  1  mode select to the adder/subtractor: 1 = subtract (A - B), 0 = add.
REQ-010 sum_s  input  4  result bits S3..S0 returned by the adder/subtractor.
REQ-011 sum_cout  input  1  Cout returned by the adder/subtractor; in subtract mode, 1 = no borrow (A >= B).
REQ-012 quotient  output  4  registered quotient of the last completed operation.
REQ-013 remainder  output  4  registered remainder of the last completed operation.
REQ-014 busy  output  1  high while state = CALC.
REQ-015 done  output  1  one-cycle pulse when quotient and remainder are updated.
REQ-016 div_err  output  1  registered; high if the last operation had divisor = 0.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-018 In IDLE with start=1, the edge SHALL: load Q <= dividend, R <= 0, D <= divisor and cnt <= 0; clear div_err; go to CALC if divisor != 0, else to DONE.
REQ-019 The block SHALL ignore start in CALC and DONE, and SHALL ignore input operand changes after the accepting edge.
REQ-020 In CALC the block SHALL form a 5-bit combinational value sh = {R, Q[3]} and drive op_a = sh[3:0], op_b = D, op_cin = 1.
REQ-021 In CALC the block SHALL compute ok = sh[4] OR sum_cout.
REQ-022 In CALC, each edge SHALL update R <= ok ? sum_s : sh[3:0] and Q <= {Q[2:0], ok}, and SHALL increment cnt.
REQ-023 The edge with cnt = 3 SHALL write quotient and remainder from the updated Q and R, and SHALL move the FSM to DONE.
REQ-024 Latency: after the accepting edge N, 4 CALC edges (N+1 to N+4) SHALL occur, and done SHALL be high in the cycle after edge N+4.
REQ-025 Divide by zero: the accepting edge SHALL set quotient = 4'hF, remainder = dividend and div_err = 1, and SHALL go to DONE; done SHALL be high in the cycle after edge N.
REQ-026 DONE SHALL assert done for exactly one cycle and then return to IDLE; a start sampled in DONE SHALL be dropped.
REQ-027 Outside CALC the block SHALL drive op_a = 0, op_b = 0 and op_cin = 0.
REQ-028 quotient, remainder and div_err SHALL hold their values until the next completion or reset.
REQ-029 R SHALL never exceed 4 bits, because R < D holds after every step.

Reset
REQ-030 Reset SHALL force state IDLE and clear quotient, remainder, busy, done, div_err, Q, R, D and cnt to 0.
REQ-031 Reset asserted mid-CALC SHALL abort the operation: no done pulse and outputs 0 on the next cycle.
REQ-032 Reset SHALL take priority over start on the same edge.
REQ-033 The first start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-034 dividend=13, divisor=3, start one cycle -> busy high for 4 cycles, then done=1 with quotient=4, remainder=1, div_err=0.
REQ-035 Operand pairs 15/1 -> 15 r0; 2/9 -> 0 r2; 15/15 -> 1 r0; 0/5 -> 0 r0; in every case done=1 four cycles after the accepting edge.
REQ-036 dividend=7, divisor=0 -> no CALC cycles; the next cycle shows done=1, div_err=1, quotient=15, remainder=7.
REQ-037 Start 13/3, then start=1 with 9/2 during CALC -> result stays 4 r1 and only one done pulse occurs.
REQ-038 Start 13/3, rst=1 at the second CALC cycle -> the next cycle shows busy=0, quotient=0, remainder=0, and no done pulse follows.
REQ-039 A bench reference model of the adder/subtractor SHALL be used; an exhaustive check over all 256 operand pairs SHALL match integer / and % for divisor != 0.

Source files
------------

// File: rtl/control_divisor_if.sv
// Handshake and operand bus between the divider controller, its requester
// and the external 4-bit adder/subtractor.
interface control_divisor_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_cin;
  logic [3:0] sum_s;
  logic       sum_cout;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_err;

  modport slave (
    input  start, dividend, divisor, sum_s, sum_cout,
    output op_a, op_b, op_cin, quotient, remainder, busy, done, div_err
  );

  modport master (
    output start, dividend, divisor, sum_s, sum_cout,
    input  op_a, op_b, op_cin, quotient, remainder, busy, done, div_err
  );
endinterface

// File: rtl/control_divisor.sv
// Restoring 4-bit unsigned divider controller; the trial subtraction is
// performed by an external adder/subtractor driven through op_a/op_b/op_cin.
module control_divisor (
  input  logic               clk,
  input  logic               rst,
  control_divisor_if.slave   ctl
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] q_reg, q_next;
  logic [3:0] r_reg, r_next;
  logic [3:0] d_reg, d_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [3:0] quotient_reg, quotient_next;
  logic [3:0] remainder_reg, remainder_next;
  logic       div_err_reg, div_err_next;

  logic [4:0] sh;
  logic       ok;
  logic [3:0] op_a_c, op_b_c;
  logic       op_cin_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      q_reg         <= 4'd0;
      r_reg         <= 4'd0;
      d_reg         <= 4'd0;
      cnt_reg       <= 2'd0;
      quotient_reg  <= 4'd0;
      remainder_reg <= 4'd0;
      div_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      r_reg         <= r_next;
      d_reg         <= d_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      div_err_reg   <= div_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    r_next         = r_reg;
    d_next         = d_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    div_err_next   = div_err_reg;
    op_a_c         = 4'd0;
    op_b_c         = 4'd0;
    op_cin_c       = 1'b0;
    // Shifted partial remainder; bit 4 set means it already exceeds any divisor.
    sh             = {r_reg, q_reg[3]};
    ok             = sh[4] | ctl.sum_cout;

    case (state_reg)
      IDLE: begin
        if (ctl.start) begin
          q_next       = ctl.dividend;
          r_next       = 4'd0;
          d_next       = ctl.divisor;
          cnt_next     = 2'd0;
          div_err_next = 1'b0;
          if (ctl.divisor != 4'd0) begin
            state_next = CALC;
          end else begin
            quotient_next  = 4'hF;
            remainder_next = ctl.dividend;
            div_err_next   = 1'b1;
            state_next     = DONE;
          end
        end
      end
      CALC: begin
        op_a_c   = sh[3:0];
        op_b_c   = d_reg;
        op_cin_c = 1'b1;
        r_next   = ok ? ctl.sum_s : sh[3:0];
        q_next   = {q_reg[2:0], ok};
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == 2'd3) begin
          quotient_next  = {q_reg[2:0], ok};
          remainder_next = ok ? ctl.sum_s : sh[3:0];
          state_next     = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ctl.op_a      = op_a_c;
  assign ctl.op_b      = op_b_c;
  assign ctl.op_cin    = op_cin_c;
  assign ctl.quotient  = quotient_reg;
  assign ctl.remainder = remainder_reg;
  assign ctl.div_err   = div_err_reg;
  assign ctl.busy      = (state_reg == CALC);
  assign ctl.done      = (state_reg == DONE);

endmodule

// File: tb/tb_control_divisor.sv
// Self-checking bench for control_divisor with a behavioural adder/subtractor
// and a result scoreboard filled at start and drained on done.
module tb_control_divisor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_divisor_if bus ();

  control_divisor dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus.slave)
  );

  // Behavioural adder/subtractor: cin=1 computes A + ~B + 1.
  logic [4:0] alu;
  always_comb begin
    if (bus.op_cin)
      alu = {1'b0, bus.op_a} + {1'b0, ~bus.op_b} + 5'd1;
    else
      alu = {1'b0, bus.op_a} + {1'b0, bus.op_b};
  end
  assign bus.sum_s    = alu[3:0];
  assign bus.sum_cout = alu[4];

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
  } res_t;

  typedef struct {
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
    int         lat;
    int         nbusy;
  } vec_t;

  res_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [3:0] b);
    res_t e;
    if (b == 4'd0) begin
      e.q = 4'hF; e.r = a; e.err = 1'b1;
    end else begin
      e.q = 4'(a / b); e.r = 4'(a % b); e.err = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Called at a negedge; the next posedge is the accepting edge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 4'($urandom);
    bus.divisor  = 4'($urandom);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int   lat   = 0;
    int   nbusy = 0;
    bit   seen  = 1'b0;
    res_t e;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn %s: q=%0d r=%0d err=%0d lat=%0d (exp q=%0d r=%0d err=%0d)",
                 tag, bus.quotient, bus.remainder, bus.div_err, lat, e.q, e.r, e.err);
        chk({tag, "_quotient"}, 32'(bus.quotient), 32'(e.q));
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'(e.r));
        chk({tag, "_div_err"}, 32'(bus.div_err), 32'(e.err));
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
    end
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_not_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_idle_op_cin"}, 32'(bus.op_cin), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) n++;
      if (bus.busy) nbusy++;
    end
  endtask

  initial begin
    int n, nb, lat;
    bit seen;

    vecs[0] = '{dvd: 4'd13, dvs: 4'd3,  q: 4'd4,  r: 4'd1, err: 1'b0, lat: 5, nbusy: 4};
    vecs[1] = '{dvd: 4'd15, dvs: 4'd1,  q: 4'd15, r: 4'd0, err: 1'b0, lat: 5, nbusy: 4};
    vecs[2] = '{dvd: 4'd2,  dvs: 4'd9,  q: 4'd0,  r: 4'd2, err: 1'b0, lat: 5, nbusy: 4};
    vecs[3] = '{dvd: 4'd15, dvs: 4'd15, q: 4'd1,  r: 4'd0, err: 1'b0, lat: 5, nbusy: 4};
    vecs[4] = '{dvd: 4'd0,  dvs: 4'd5,  q: 4'd0,  r: 4'd0, err: 1'b0, lat: 5, nbusy: 4};
    vecs[5] = '{dvd: 4'd7,  dvs: 4'd0,  q: 4'd15, r: 4'd7, err: 1'b1, lat: 1, nbusy: 0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_quotient", 32'(bus.quotient), 32'd0);
    chk("reset_remainder", 32'(bus.remainder), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_div_err", 32'(bus.div_err), 32'd0);
    chk("reset_op_a", 32'(bus.op_a), 32'd0);
    chk("reset_op_b", 32'(bus.op_b), 32'd0);
    chk("reset_op_cin", 32'(bus.op_cin), 32'd0);

    // Start on the very first edge after reset release.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{q: vecs[i].q, r: vecs[i].r, err: vecs[i].err});
      start_op(vecs[i].dvd, vecs[i].dvs);
      wait_done($sformatf("vec%0d_%0d_by_%0d", i, vecs[i].dvd, vecs[i].dvs),
                vecs[i].lat, vecs[i].nbusy);
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        push_exp(4'(a), 4'(b));
        start_op(4'(a), 4'(b));
        wait_done($sformatf("exh_%0d_by_%0d", a, b), (b == 0) ? 1 : 5, (b == 0) ? 0 : 4);
      end
    end

    // start held high during CALC and through the DONE edge must be ignored.
    push_exp(4'd13, 4'd3);
    start_op(4'd13, 4'd3);
    @(negedge clk);
    chk("busy_first_calc", 32'(bus.busy), 32'd1);
    chk("calc_op_cin", 32'(bus.op_cin), 32'd1);
    bus.start = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor = 4'd2;
    seen = 1'b0;
    lat = 1;
    for (int i = 2; i <= 12 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        lat = i;
      end
    end
    chk("restart_done_seen", 32'(seen), 32'd1);
    chk("restart_latency", 32'(lat), 32'd5);
    chk("restart_quotient", 32'(bus.quotient), 32'd4);
    chk("restart_remainder", 32'(bus.remainder), 32'd1);
    if (sb.size() > 0) void'(sb.pop_front());
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    count_done(8, n, nb);
    $display("txn restart_ignore: extra_done=%0d busy_cycles=%0d q=%0d r=%0d",
             n, nb, bus.quotient, bus.remainder);
    chk("restart_extra_done", 32'(n), 32'd0);
    chk("restart_no_new_calc", 32'(nb), 32'd0);
    chk("restart_hold_quotient", 32'(bus.quotient), 32'd4);

    // Reset during the second CALC cycle aborts without a done pulse.
    start_op(4'd13, 4'd3);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    $display("txn abort: busy=%0d q=%0d r=%0d done=%0d",
             bus.busy, bus.quotient, bus.remainder, bus.done);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_quotient", 32'(bus.quotient), 32'd0);
    chk("abort_remainder", 32'(bus.remainder), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    count_done(8, n, nb);
    chk("abort_no_done", 32'(n), 32'd0);
    chk("abort_no_busy", 32'(nb), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
